// File: rtl/pipeline_hazard_unit.sv
// Hazard detection and flush control for the 5-stage MIPS pipeline.
// Tracks in-flight destinations in a shift-register scoreboard behind ID.
module pipeline_hazard_unit #(
    parameter int REG_ADDR_W     = 5,
    parameter int DEPTH          = 3,
    parameter int FORWARDING     = 1,
    parameter int REDIRECT_STAGE = 1,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [REG_ADDR_W-1:0]       id_rs,
    input  logic [REG_ADDR_W-1:0]       id_rt,
    input  logic                        id_uses_rs,
    input  logic                        id_uses_rt,
    input  logic [REG_ADDR_W-1:0]       id_dst,
    input  logic                        id_reg_write,
    input  logic                        id_mem_read,
    input  logic                        redirect,
    output logic                        stall_if_id,
    output logic                        bubble_id_ex,
    output logic [REDIRECT_STAGE+1:0]   flush_vec,
    output logic [CNT_W-1:0]            stall_cycles,
    output logic [CNT_W-1:0]            redirect_count
);

    logic [DEPTH-1:0]      sb_valid;
    logic [DEPTH-1:0]      sb_wr;
    logic [DEPTH-1:0]      sb_ld;
    logic [REG_ADDR_W-1:0] sb_dst [DEPTH];

    logic [DEPTH-1:0] match;
    logic             rs_live;
    logic             rt_live;
    logic             raw;
    logic             hazard;

    assign rs_live = id_uses_rs && (id_rs != '0);
    assign rt_live = id_uses_rt && (id_rt != '0);

    always_comb begin
        match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = sb_valid[k] && sb_wr[k] &&
                       ((rs_live && (id_rs == sb_dst[k])) ||
                        (rt_live && (id_rt == sb_dst[k])));
        end
    end

    // With forwarding only a load one stage ahead cannot be bypassed.
    always_comb begin
        if (FORWARDING != 0) begin
            raw = match[0] && sb_ld[0];
        end else begin
            raw = |match;
        end
    end

    assign hazard       = id_valid && raw && !redirect;
    assign stall_if_id  = hazard;
    assign bubble_id_ex = hazard;
    assign flush_vec    = {(REDIRECT_STAGE+2){redirect}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_valid <= '0;
            sb_wr    <= '0;
            sb_ld    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sb_dst[k] <= '0;
            end
        end else begin
            sb_valid[0] <= id_valid && !hazard && !redirect;
            sb_wr[0]    <= id_reg_write && (id_dst != '0);
            sb_ld[0]    <= id_mem_read;
            sb_dst[0]   <= id_dst;
            for (int k = 1; k < DEPTH; k++) begin
                // Entries younger than the redirecting instruction are squashed.
                sb_valid[k] <= sb_valid[k-1] &&
                               !(redirect && ((k - 1) < REDIRECT_STAGE));
                sb_wr[k]    <= sb_wr[k-1];
                sb_ld[k]    <= sb_ld[k-1];
                sb_dst[k]   <= sb_dst[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (stall_if_id && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (redirect && (redirect_count != '1)) begin
                redirect_count <= redirect_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: one forwarding instance and
// one non-forwarding instance with narrow counters, sharing the same inputs.
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] id_dst;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       redirect;

    logic        f1_stall, f1_bubble;
    logic [2:0]  f1_flush;
    logic [15:0] f1_stall_cnt, f1_redir_cnt;
    logic        f0_stall, f0_bubble;
    logic [2:0]  f0_flush;
    logic [3:0]  f0_stall_cnt, f0_redir_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .REG_ADDR_W(5), .DEPTH(3), .FORWARDING(1),
        .REDIRECT_STAGE(1), .CNT_W(16)
    ) u_f1 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst(id_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .redirect(redirect),
        .stall_if_id(f1_stall), .bubble_id_ex(f1_bubble),
        .flush_vec(f1_flush), .stall_cycles(f1_stall_cnt),
        .redirect_count(f1_redir_cnt)
    );

    pipeline_hazard_unit #(
        .REG_ADDR_W(5), .DEPTH(3), .FORWARDING(0),
        .REDIRECT_STAGE(1), .CNT_W(4)
    ) u_f0 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst(id_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .redirect(redirect),
        .stall_if_id(f0_stall), .bubble_id_ex(f0_bubble),
        .flush_vec(f0_flush), .stall_cycles(f0_stall_cnt),
        .redirect_count(f0_redir_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0;
        id_uses_rs = 0; id_uses_rt = 0;
        id_dst = 0; id_reg_write = 0; id_mem_read = 0;
        redirect = 0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic [4:0] dst, input logic wr,
                         input logic ld);
        id_valid = 1; id_rs = rs; id_rt = rt;
        id_uses_rs = urs; id_uses_rt = urt;
        id_dst = dst; id_reg_write = wr; id_mem_read = ld;
        redirect = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
        #1;
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        tick();
        #1;
        chk("rst_stall", {31'b0, f1_stall}, 32'd0);
        chk("rst_bubble", {31'b0, f1_bubble}, 32'd0);
        chk("rst_flush", {29'b0, f1_flush}, 32'd0);
        chk("rst_f1_cnt", {16'b0, f1_stall_cnt}, 32'd0);
        chk("rst_f0_cnt", {28'b0, f0_redir_cnt}, 32'd0);
        reset = 0;
        tick();

        // Load-use with forwarding: exactly one stall cycle.
        instr(0, 0, 0, 0, 5'd8, 1, 1);
        #1;
        chk("lu_c0_stall", {31'b0, f1_stall}, 32'd0);
        tick();
        instr(5'd8, 1, 0, 0, 5'd10, 1, 0);
        #1;
        chk("lu_c1_stall", {31'b0, f1_stall}, 32'd1);
        chk("lu_c1_bubble", {31'b0, f1_bubble}, 32'd1);
        tick();
        chk("lu_c2_stall", {31'b0, f1_stall}, 32'd0);
        chk("lu_cnt", {16'b0, f1_stall_cnt}, 32'd1);
        do_reset();

        // Reset asserted mid-stall clears everything immediately.
        instr(0, 0, 0, 0, 5'd8, 1, 1);
        tick();
        instr(5'd8, 1, 0, 0, 5'd10, 1, 0);
        #1;
        chk("mr_pre_stall", {31'b0, f1_stall}, 32'd1);
        reset = 1;
        #1;
        chk("mr_stall", {31'b0, f1_stall}, 32'd0);
        chk("mr_bubble", {31'b0, f1_bubble}, 32'd0);
        chk("mr_flush", {29'b0, f1_flush}, 32'd0);
        tick();
        reset = 0;
        #1;
        chk("mr_post_stall", {31'b0, f1_stall}, 32'd0);
        tick();
        chk("mr_cnt", {16'b0, f1_stall_cnt}, 32'd0);
        do_reset();

        // No forwarding: ALU producer stalls consumer for three cycles.
        instr(0, 0, 0, 0, 5'd9, 1, 0);
        tick();
        instr(0, 0, 5'd9, 1, 5'd11, 1, 0);
        #1;
        chk("nf_c1_stall", {31'b0, f0_stall}, 32'd1);
        chk("nf_c1_f1", {31'b0, f1_stall}, 32'd0);
        tick();
        chk("nf_c2_stall", {31'b0, f0_stall}, 32'd1);
        tick();
        chk("nf_c3_stall", {31'b0, f0_stall}, 32'd1);
        tick();
        chk("nf_c4_stall", {31'b0, f0_stall}, 32'd0);
        chk("nf_cnt", {28'b0, f0_stall_cnt}, 32'd3);
        do_reset();

        // Register 0 never creates a hazard.
        instr(0, 0, 0, 0, 5'd0, 1, 1);
        tick();
        instr(5'd0, 1, 5'd0, 1, 5'd12, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("r0_f1_stall", {31'b0, f1_stall}, 32'd0);
            chk("r0_f0_stall", {31'b0, f0_stall}, 32'd0);
            tick();
        end
        do_reset();

        // Redirect wins over a simultaneous load-use hazard.
        instr(0, 0, 0, 0, 5'd8, 1, 1);
        tick();
        instr(5'd8, 1, 0, 0, 5'd10, 1, 0);
        redirect = 1;
        #1;
        chk("rd_stall", {31'b0, f1_stall}, 32'd0);
        chk("rd_bubble", {31'b0, f1_bubble}, 32'd0);
        chk("rd_flush", {29'b0, f1_flush}, 32'b111);
        tick();
        redirect = 0;
        #1;
        chk("rd_next_f1", {31'b0, f1_stall}, 32'd0);
        chk("rd_next_f0", {31'b0, f0_stall}, 32'd0);
        chk("rd_next_flush", {29'b0, f1_flush}, 32'd0);
        chk("rd_cnt", {16'b0, f1_redir_cnt}, 32'd1);
        do_reset();

        // Self-dependent stream keeps re-stalling; 4-bit counter saturates.
        instr(5'd9, 1, 0, 0, 5'd9, 1, 0);
        for (int i = 0; i < 8; i++) tick();
        chk("sat_mid", {28'b0, f0_stall_cnt}, 32'd6);
        for (int i = 0; i < 32; i++) tick();
        chk("sat_end", {28'b0, f0_stall_cnt}, 32'd15);
        chk("sat_f1", {16'b0, f1_stall_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised hazard detection and flush controller for the 5-stage pipelined MIPS core.
- Generalises the unconditional-enable pipe registers so the pipeline supports stalls and flushes.
- Keeps a shift-register scoreboard of in-flight destination registers; detects RAW hazards for the instruction in ID.
- Drives stall, bubble and per-pipe-register flush controls, plus saturating performance counters for stall cycles and redirects.

Parameters:
REG_ADDR_W, 5, register-file address width
DEPTH, 3, scoreboard entries tracked after ID (0=EX, 1=MEM, 2=WB)
FORWARDING, 1, 1 = forwarding paths exist (only load-use stalls); 0 = stall on any pending write
REDIRECT_STAGE, 1, scoreboard index of the stage that resolves branch/jump/JR (1=MEM); legal range 0..DEPTH-1
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_ADDR_W  source register 1 of the ID instruction
id_rt  in  REG_ADDR_W  source register 2 of the ID instruction
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dst  in  REG_ADDR_W  destination register of the ID instruction (after RegDst/JAL selection)
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
redirect  in  1  instruction at REDIRECT_STAGE changes the PC (taken branch, J, JAL, JR)
stall_if_id  out  1  hold the PC and the IF/ID register
bubble_id_ex  out  1  load a NOP (all control bits 0) into ID/EX
flush_vec  out  REDIRECT_STAGE+2  bit j clears pipe register j (0=IF/ID, 1=ID/EX, 2=EX/MEM, ...)
stall_cycles  out  CNT_W  count of cycles with stall_if_id=1, saturating
redirect_count  out  CNT_W  count of cycles with redirect=1, saturating

Behaviour:
- Scoreboard entry fields: valid, dst, wr, ld.
  - wr is 1 only if reg_write=1 and dst!=0.
  - Register 0 never causes a hazard.
- Match of entry k: valid_k and wr_k and ((id_uses_rs and id_rs==dst_k) or (id_uses_rt and id_rt==dst_k)), with the compared source != 0.
- Raw hazard, FORWARDING=1: entry 0 matches and ld_0=1 (load-use).
- Raw hazard, FORWARDING=0: any entry k in 0..DEPTH-1 matches.
  - This holds because the register file writes at the clock edge and the WB entry is still pending during its cycle.
- Combinational outputs:
  - hazard = id_valid and raw hazard and not redirect.
  - stall_if_id = hazard.
  - bubble_id_ex = hazard.
  - flush_vec = all ones when redirect=1, else 0.
- Redirect has priority over stall.
- Same cycle, redirect=1 and a raw hazard: no stall; the younger instructions are flushed.
- Scoreboard update each rising edge:
  - Entry 0 is loaded with the ID instruction.
  - Entry 0 is invalid instead if id_valid=0, hazard=1 or redirect=1.
  - Entry k (k>=1) takes entry k-1.
  - If redirect=1 and k-1 < REDIRECT_STAGE, entry k is invalid instead: those instructions are younger than the redirecting one.
  - The entry at DEPTH-1 shifts out.
- Latency:
  - Hazard response is same-cycle (combinational).
  - A load-use stall lasts exactly 1 cycle.
  - A FORWARDING=0 stall lasts until the producer leaves entry DEPTH-1 (at most DEPTH cycles).
- Counters:
  - stall_cycles increments on each edge with stall_if_id=1.
  - redirect_count increments on each edge with redirect=1.
  - Both hold at all-ones (saturate, no wrap).
- Reset, asynchronous, legal at any time including mid-stall:
  - All scoreboard entries are invalid; both counters are 0.
  - Consequently stall_if_id=0, bubble_id_ex=0 and flush_vec=0 while reset is high.
  - The first edge after deassertion behaves as a normal cycle.
- id_valid=0 never stalls and inserts an invalid entry.

Test Plan:
- Reset mid-operation: load the scoreboard with a load to r8, assert reset between edges → outputs 0 immediately; after release, a consumer of r8 does not stall; stall_cycles=0.
- FORWARDING=1 load-use: cycle 0 ID = load dst=8 (mem_read=1); cycle 1 ID uses rs=8 → stall_if_id=1 and bubble_id_ex=1 in cycle 1 only; cycle 2 → 0; stall_cycles=1.
- FORWARDING=0, DEPTH=3: ALU op dst=9, next instruction uses rt=9 → stall held 3 consecutive cycles, released in the 4th; stall_cycles=3.
- Register 0: reg_write=1 with dst=0, consumer with rs=0 and rt=0 → no stall in any cycle, both FORWARDING settings.
- Redirect during hazard: a load-use hazard present and redirect=1 in the same cycle → stall_if_id=0, flush_vec=3'b111; entry 0 and entries below REDIRECT_STAGE invalid next cycle, so no spurious stall; redirect_count=1.
- Counter saturation with CNT_W=4: hold a FORWARDING=0 stall for 20 cycles (e.g. id_valid=1 with a persistent match) → stall_cycles stops at 15.
